// File: rtl/frame_peak_tracker_pkg.sv
// Shared constants for the frame peak tracker: FSM state codes and default sizing.
package frame_peak_tracker_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_FRAME_LEN = 8;

endpackage

// File: rtl/frame_peak_tracker_max_cmp.sv
// Two-input unsigned maximum; gt flags that b strictly beats a, so ties favour a.
module max_cmp
  import frame_peak_tracker_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             gt
);

  assign gt = (b > a);
  assign y  = gt ? b : a;

endmodule

// File: rtl/frame_peak_tracker.sv
// Tracks the running peak of an unsigned sample stream over fixed-length frames and
// reports each frame's peak value with the index of its first occurrence.
module frame_peak_tracker
  import frame_peak_tracker_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_WIDTH,
  parameter  int FRAME_LEN = DEFAULT_FRAME_LEN,
  localparam int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] run_max_reg, run_max_next;
  logic [IDX_W-1:0] run_idx_reg, run_idx_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_max_reg, out_max_next;
  logic [IDX_W-1:0] out_idx_reg, out_idx_next;

  logic [WIDTH-1:0] cmp_y;
  logic             cmp_gt;

  max_cmp #(.WIDTH(WIDTH)) u_max_cmp (
    .a  (run_max_reg),
    .b  (in_data),
    .y  (cmp_y),
    .gt (cmp_gt)
  );

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    run_max_next   = run_max_reg;
    run_idx_next   = run_idx_reg;
    out_valid_next = 1'b0;
    out_max_next   = out_max_reg;
    out_idx_next   = out_idx_reg;

    // clear outranks a coincident sample, which is simply dropped
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
    end else if (in_valid) begin
      if (state_reg == IDLE) begin
        run_max_next = in_data;
        run_idx_next = '0;
        count_next   = IDX_W'(1);
        state_next   = ACCUM;
      end else if (count_reg == LAST_IDX) begin
        out_max_next   = cmp_y;
        out_idx_next   = cmp_gt ? count_reg : run_idx_reg;
        out_valid_next = 1'b1;
        count_next     = '0;
        state_next     = IDLE;
      end else begin
        if (cmp_gt) begin
          run_max_next = cmp_y;
          run_idx_next = count_reg;
        end
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      run_max_reg   <= '0;
      run_idx_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_max_reg   <= '0;
      out_idx_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      run_max_reg   <= run_max_next;
      run_idx_reg   <= run_idx_next;
      out_valid_reg <= out_valid_next;
      out_max_reg   <= out_max_next;
      out_idx_reg   <= out_idx_next;
    end
  end

  assign busy      = (state_reg == ACCUM);
  assign out_valid = out_valid_reg;
  assign out_max   = out_max_reg;
  assign out_idx   = out_idx_reg;

endmodule

// File: tb/tb_frame_peak_tracker.sv
// Bench for frame_peak_tracker: directed frames plus random traffic against a
// frame-level reference model that collects samples and scans each full frame.
module tb_frame_peak_tracker;

  localparam int W  = 4;
  localparam int FL = 8;
  localparam int IW = $clog2(FL);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          clear = 1'b0;
  logic          busy, out_valid;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [W-1:0]  fr[$];
  logic          exp_valid = 1'b0;
  logic          exp_busy = 1'b0;
  logic [W-1:0]  exp_max = '0;
  logic [IW-1:0] exp_idx = '0;

  logic [W-1:0] frame_a [FL] = '{4'hB, 4'hA, 4'h9, 4'h0, 4'h5, 4'hC, 4'h2, 4'h7};
  logic [W-1:0] frame_b [FL] = '{4'h7, 4'hD, 4'h1, 4'h0, 4'hD, 4'hC, 4'h4, 4'hD};

  always #5 clk = ~clk;

  frame_peak_tracker #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .busy      (busy),
    .out_valid (out_valid),
    .out_max   (out_max),
    .out_idx   (out_idx)
  );

  // Drive one cycle and advance the model; outputs are then sampled 1 time unit after the edge.
  task automatic run_cycle(input logic v, input logic [W-1:0] d, input logic c, input logic r);
    int bi;
    in_valid = v;
    in_data  = d;
    clear    = c;
    rst      = r;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    if (r) begin
      fr.delete();
      exp_max = '0;
      exp_idx = '0;
    end else if (c) begin
      fr.delete();
    end else if (v) begin
      fr.push_back(d);
      if (fr.size() == FL) begin
        bi = 0;
        for (int i = 1; i < FL; i++) if (fr[i] > fr[bi]) bi = i;
        exp_max   = fr[bi];
        exp_idx   = IW'(bi);
        exp_valid = 1'b1;
        fr.delete();
        $display("frame done: peak=%h idx=%0d", exp_max, exp_idx);
      end
    end
    exp_busy = (fr.size() != 0);
  endtask

  task automatic test_reset();
    run_cycle(1'b0, '0, 1'b0, 1'b1);
    run_cycle(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if ({busy, out_valid, out_max, out_idx} !== {1'b0, 1'b0, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset: got busy=%b valid=%b max=%h idx=%0d want 0 0 0 0", busy, out_valid, out_max, out_idx);
    end
    run_cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_frame_basic();
    for (int i = 0; i < FL; i++) begin
      run_cycle(1'b1, frame_a[i], 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
    checks++;
    if ({out_valid, out_max, out_idx} !== {1'b1, 4'hC, 3'd5}) begin
      errors++;
      $display("FAIL basic_result: got v=%b max=%h idx=%0d want 1 c 5", out_valid, out_max, out_idx);
    end
    run_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({out_valid, out_max, out_idx} !== {1'b0, 4'hC, 3'd5}) begin
      errors++;
      $display("FAIL basic_pulse_len: got v=%b max=%h idx=%0d want 0 c 5", out_valid, out_max, out_idx);
    end
  endtask

  task automatic test_tie();
    for (int i = 0; i < FL; i++) begin
      run_cycle(1'b1, frame_b[i], 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL tie[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
    checks++;
    if ({out_valid, busy, out_max, out_idx} !== {1'b1, 1'b0, 4'hD, 3'd1}) begin
      errors++;
      $display("FAIL tie_result: got v=%b b=%b max=%h idx=%0d want 1 0 d 1", out_valid, busy, out_max, out_idx);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < FL + 3; i++) begin
      if (i >= 3 && i < 6) run_cycle(1'b0, 4'hF, 1'b0, 1'b0);
      else run_cycle(1'b1, frame_a[(i < 3) ? i : i - 3], 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL gaps[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
    checks++;
    if ({out_valid, out_max, out_idx} !== {1'b1, 4'hC, 3'd5}) begin
      errors++;
      $display("FAIL gaps_result: got v=%b max=%h idx=%0d want 1 c 5", out_valid, out_max, out_idx);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * FL; i++) begin
      run_cycle(1'b1, (i < FL) ? frame_a[i] : 4'h3, 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
    checks++;
    if ({out_valid, out_max, out_idx} !== {1'b1, 4'h3, 3'd0}) begin
      errors++;
      $display("FAIL b2b_result: got v=%b max=%h idx=%0d want 1 3 0", out_valid, out_max, out_idx);
    end
  endtask

  task automatic test_clear();
    logic [W-1:0] pre [4] = '{4'h2, 4'hF, 4'h4, 4'h1};
    for (int i = 0; i < 13; i++) begin
      if (i < 4)       run_cycle(1'b1, pre[i], 1'b0, 1'b0);
      else if (i == 4) run_cycle(1'b1, 4'hE, 1'b1, 1'b0);
      else             run_cycle(1'b1, 4'h1, 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL clear[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
    checks++;
    if ({out_valid, out_max, out_idx} !== {1'b1, 4'h1, 3'd0}) begin
      errors++;
      $display("FAIL clear_result: got v=%b max=%h idx=%0d want 1 1 0", out_valid, out_max, out_idx);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 5; i++) run_cycle(1'b1, W'($urandom_range(0, 15)), 1'b0, 1'b0);
    run_cycle(1'b1, 4'h9, 1'b0, 1'b1);
    checks++;
    if ({busy, out_valid, out_max, out_idx} !== {1'b0, 1'b0, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b valid=%b max=%h idx=%0d want 0 0 0 0", busy, out_valid, out_max, out_idx);
    end
    for (int i = 0; i < FL; i++) begin
      run_cycle(1'b1, W'($urandom_range(0, 15)), 1'b0, 1'b0);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL rst_after[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
  endtask

  task automatic test_random();
    logic v, c, r;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 149) == 0);
      // narrow value range on some cycles to provoke ties
      run_cycle(v, ($urandom_range(0, 1) != 0) ? W'($urandom_range(12, 15)) : W'($urandom), c, r);
      checks++;
      if ({out_valid, busy, out_max, out_idx} !== {exp_valid, exp_busy, exp_max, exp_idx}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b b=%b max=%h idx=%0d want v=%b b=%b max=%h idx=%0d",
                 i, out_valid, busy, out_max, out_idx, exp_valid, exp_busy, exp_max, exp_idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_tie();
    test_gaps();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
